div_unit_seq: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/div_unit_seq.sv | 150 +++++++++++++++
 tb/tb_div_unit_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides magnitudes one quotient bit per cycle, then applies the sign to the selected result.
module div_unit_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] rd_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // Operand decode at start
    logic             in_signed;
    logic             rs1_neg, rs2_neg;
    logic [WIDTH-1:0] rs1_mag, rs2_mag;
    logic             div_zero, sgn_ovf;

    assign in_signed = ~op_i[0];
    assign rs1_neg   = in_signed & rs1_i[WIDTH-1];
    assign rs2_neg   = in_signed & rs2_i[WIDTH-1];
    assign rs1_mag   = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag   = rs2_neg ? -rs2_i : rs2_i;
    assign div_zero  = (rs2_i == '0);
    assign sgn_ovf   = in_signed & (rs1_i == MinNeg) & (rs2_i == '1);

    // One restoring step; quotient bits accumulate in dvd as the dividend shifts out
    logic [WIDTH:0]   rem_shift;
    logic             q_bit;
    logic [WIDTH-1:0] rem_sub, rem_next, dvd_next, result;

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign q_bit     = (rem_shift >= {1'b0, dvs_q});
    // When q_bit is set the true difference is below 2^WIDTH, so WIDTH bits suffice
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    assign rem_next  = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
    assign dvd_next  = {dvd_q[WIDTH-2:0], q_bit};
    assign result    = is_rem_q ? (neg_rem_q ? -rem_next : rem_next)
                                : (neg_quo_q ? -dvd_next : dvd_next);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rd_d      = rd_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    is_rem_d  = op_i[1];
                    neg_quo_d = rs1_neg ^ rs2_neg;
                    neg_rem_d = rs1_neg;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvd_d     = rs1_mag;
                    dvs_d     = rs2_mag;
                    if (div_zero) begin
                        rd_d    = op_i[1] ? rs1_i : '1;
                        state_d = StDone;
                    end else if (sgn_ovf) begin
                        rd_d    = op_i[1] ? '0 : MinNeg;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    rd_d    = result;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush overrides everything, including a same-cycle start
        if (kill_i) begin
            state_d = StIdle;
            cnt_d   = cnt_q;
            rem_d   = rem_q;
            dvd_d   = dvd_q;
            dvs_d   = dvs_q;
            rd_d    = rd_q;
            is_rem_d  = is_rem_q;
            neg_quo_d = neg_quo_q;
            neg_rem_d = neg_rem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rd_q      <= rd_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign valid_o = (state_q == StDone);
    assign rd_o    = rd_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Self-checking bench for div_unit_seq: directed RV32M cases, random ops against an
// arithmetic reference, start-while-busy, kill and asynchronous reset scenarios.
module tb_div_unit_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] rs1_i = '0;
    logic [W-1:0] rs2_i = '0;
    logic         kill_i = 1'b0;
    logic         busy_o, valid_o;
    logic [W-1:0] rd_o;

    int vectors = 0;
    int errors  = 0;

    localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

    div_unit_seq #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .op_i   (op_i),
        .rs1_i  (rs1_i),
        .rs2_i  (rs2_i),
        .kill_i (kill_i),
        .busy_o (busy_o),
        .valid_o(valid_o),
        .rd_o   (rd_o)
    );

    always #5 clk = ~clk;

    // RISC-V semantics via 64-bit arithmetic; only divide-by-zero needs a rule of its own
    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (b == '0) return op[1] ? a : '1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OpDiv:   return W'(sa / sb);
            OpDivu:  return W'(ua / ub);
            OpRem:   return W'(sa % sb);
            default: return W'(ua % ub);
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (b == '0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op at a negedge, then check latency, result and the single-cycle pulse.
    // Returns at the negedge after DONE, so a caller may start again immediately.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        logic [W-1:0] exp;
        int lat, n;
        exp = ref_model(op, a, b);
        lat = ref_latency(op, a, b);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        vectors++;
        if (rd_o !== exp) begin
            errors++;
            $display("FAIL %s rd_o: got %h want %h (op=%0d a=%h b=%h)", name, rd_o, exp, op, a, b);
        end
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: valid=%b busy=%b want 0/0 after DONE", name, valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || rd_o !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b rd=%h want 0/0/0", busy_o, valid_o, rd_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(OpDivu, 32'd100, 32'd7, "divu_100_7");
        run_op(OpRemu, 32'd100, 32'd7, "remu_100_7");
        run_op(OpDiv, -32'sd7, 32'd2, "div_m7_2");
        run_op(OpRem, -32'sd7, 32'd2, "rem_m7_2");
        run_op(OpRem, 32'd7, -32'sd2, "rem_7_m2");
        run_op(OpDiv, -32'sd8, -32'sd2, "div_m8_m2");
        run_op(OpDivu, 32'd5, 32'd0, "divu_by_zero");
        run_op(OpRem, 32'h8000_0001, 32'd0, "rem_by_zero");
        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");
        run_op(OpDivu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = W'($urandom_range(1, 15));
                1: b = -W'($urandom_range(1, 15));
                2: b = '0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    // Second start while busy is dropped; a start right after DONE is accepted
    task automatic test_back_to_back();
        int n;
        bit early;
        start_i = 1'b1; op_i = OpDivu; rs1_i = 32'd9; rs2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        early = 1'b0;
        while (n < 33) begin
            if (valid_o) early = 1'b1;
            if (n == 10) begin
                start_i = 1'b1; rs1_i = 32'd50; rs2_i = 32'd5;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        vectors++;
        if (early || valid_o !== 1'b1 || rd_o !== 32'd3) begin
            errors++;
            $display("FAIL ignore_start: early=%b valid=%b rd=%h want 0/1/00000003",
                     early, valid_o, rd_o);
        end
        @(negedge clk);
        run_op(OpDivu, 32'd50, 32'd5, "b2b_second");
    endtask

    task automatic test_kill();
        bit seen;
        start_i = 1'b1; op_i = OpDivu; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_calc: busy=%b valid=%b want 0/0", busy_o, valid_o);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL kill_no_valid: got a valid pulse, want none");
        end
        // kill with start in IDLE: start not accepted
        start_i = 1'b1; kill_i = 1'b1; rs2_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_start: busy=%b valid=%b want 0/0", busy_o, valid_o);
        end
        // kill during DONE: pulse already present, following cycle idle
        start_i = 1'b1; op_i = OpDivu; rs1_i = 32'd5; rs2_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0;
        kill_i = 1'b1;
        #1;
        vectors++;
        if (valid_o !== 1'b1 || rd_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL kill_done: valid=%b rd=%h want 1/ffffffff", valid_o, rd_o);
        end
        @(negedge clk);
        kill_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_done_after: busy=%b valid=%b want 0/0", busy_o, valid_o);
        end
    endtask

    task automatic test_reset_mid_op();
        start_i = 1'b1; op_i = OpDivu; rs1_i = 32'd77; rs2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || rd_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b rd=%h want 0/0/0", busy_o, valid_o, rd_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_kill();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
